// File: rtl/fft_pkg.sv
// Shared constants, bank-state type and bin bit-reversal helper for the 16-point FFT output stage.
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/fft_ser_bank.sv
// One ping-pong half: 16 complex samples written in parallel, read one slot at a time,
// with a FULL/EMPTY flag set on write and cleared once the frame has drained.
module fft_ser_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        clear,
    input  logic [DATA_WIDTH*FFT_N-1:0] wr_real,
    input  logic [DATA_WIDTH*FFT_N-1:0] wr_imag,
    input  logic [FFT_LOG2N-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_real,
    output logic [DATA_WIDTH-1:0]       rd_imag,
    output logic                        full
);

    logic [2*DATA_WIDTH-1:0] mem [FFT_N];
    bank_state_t             state;

    // NOTE: the sample storage is deliberately not reset; the state flag alone
    // decides whether its contents are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem[i] <= {wr_real[DATA_WIDTH*(FFT_N-i)-1 -: DATA_WIDTH],
                           wr_imag[DATA_WIDTH*(FFT_N-i)-1 -: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else if (wr_en) begin
            state <= FULL;
        end else if (clear) begin
            state <= EMPTY;
        end
    end

    assign full               = (state == FULL);
    assign {rd_real, rd_imag} = mem[rd_addr];

endmodule

// File: rtl/fft_output_serializer.sv
// Captures round-4 FFT frames into two banks and streams them out one bin per cycle.
// Define FFT_SER_BITREV_EN to emit bins in natural frequency order instead of raw round-4 order.
module fft_output_serializer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*FFT_N-1:0] x_in_flat_real,
    input  logic [DATA_WIDTH*FFT_N-1:0] x_in_flat_imag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_real,
    output logic [DATA_WIDTH-1:0]       out_imag,
    output logic [FFT_LOG2N-1:0]        out_index,
    output logic                        out_last,
    output logic                        overflow
);

`ifdef FFT_SER_BITREV_EN
    localparam bit BITREV_EN = 1'b1;
`else
    localparam bit BITREV_EN = 1'b0;
`endif

    localparam logic [FFT_LOG2N-1:0] LAST_SLOT = FFT_LOG2N'(FFT_N - 1);

    logic                  wr_bank;
    logic                  rd_bank;
    logic [FFT_LOG2N-1:0]  rd_cnt;

    logic [1:0]            full;
    logic [1:0]            wr_en;
    logic [1:0]            clear;
    logic [1:0]            nxt_full;
    logic [DATA_WIDTH-1:0] bank_real [2];
    logic [DATA_WIDTH-1:0] bank_imag [2];
    logic [DATA_WIDTH-1:0] in_real   [FFT_N];
    logic [DATA_WIDTH-1:0] in_imag   [FFT_N];

    logic                  accept;
    logic                  xfer;
    logic                  last_xfer;
    logic [FFT_LOG2N-1:0]  nxt_cnt;
    logic [FFT_LOG2N-1:0]  nxt_bin;
    logic [FFT_LOG2N-1:0]  nxt_index;
    logic                  nxt_rd_bank;
    logic                  nxt_valid;
    logic [DATA_WIDTH-1:0] nxt_real;
    logic [DATA_WIDTH-1:0] nxt_imag;

    // in_ready depends only on registered bank state, never on out_ready.
    assign in_ready  = !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (rd_cnt == LAST_SLOT);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign wr_en[b] = accept && (wr_bank == 1'(b));
        assign clear[b] = last_xfer && (rd_bank == 1'(b));

        fft_ser_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[b]),
            .clear   (clear[b]),
            .wr_real (x_in_flat_real),
            .wr_imag (x_in_flat_imag),
            .rd_addr (nxt_bin),
            .rd_real (bank_real[b]),
            .rd_imag (bank_imag[b]),
            .full    (full[b])
        );
    end

    // Look one cycle ahead so the output stage can be a plain register; a bank
    // being written this edge is read straight from the input buses.
    // NOTE: every always_comb output gets a default before any conditional update,
    // so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < FFT_N; i++) begin
            in_real[i] = x_in_flat_real[DATA_WIDTH*(FFT_N-i)-1 -: DATA_WIDTH];
            in_imag[i] = x_in_flat_imag[DATA_WIDTH*(FFT_N-i)-1 -: DATA_WIDTH];
        end
        nxt_full    = (full & ~clear) | wr_en;
        nxt_cnt     = xfer ? rd_cnt + 1'b1 : rd_cnt;
        nxt_rd_bank = last_xfer ? !rd_bank : rd_bank;
        nxt_valid   = nxt_full[nxt_rd_bank];
        nxt_bin     = BITREV_EN ? bitrev4(nxt_cnt) : nxt_cnt;
        nxt_index   = BITREV_EN ? nxt_cnt : bitrev4(nxt_cnt);
        nxt_real    = bank_real[nxt_rd_bank];
        nxt_imag    = bank_imag[nxt_rd_bank];
        if (wr_en[nxt_rd_bank]) begin
            nxt_real = in_real[nxt_bin];
            nxt_imag = in_imag[nxt_bin];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_bank <= !wr_bank;
            end
            rd_bank   <= nxt_rd_bank;
            rd_cnt    <= nxt_cnt;
            out_valid <= nxt_valid;
            out_real  <= nxt_valid ? nxt_real : '0;
            out_imag  <= nxt_valid ? nxt_imag : '0;
            out_index <= nxt_valid ? nxt_index : '0;
            out_last  <= nxt_valid && (nxt_cnt == LAST_SLOT);
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Self-checking bench for fft_output_serializer: directed phases with random data,
// compared against a frame-queue model. Honours FFT_SER_BITREV_EN like the design.
module tb_fft_output_serializer;

    localparam int DW = 20;
    localparam int N  = 16;

`ifdef FFT_SER_BITREV_EN
    localparam bit BITREV_EN = 1'b1;
`else
    localparam bit BITREV_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [3:0]    idx;
        logic          last;
    } samp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW*N-1:0] x_in_flat_real;
    logic [DW*N-1:0] x_in_flat_imag;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_real;
    logic [DW-1:0]   out_imag;
    logic [3:0]      out_index;
    logic            out_last;
    logic            overflow;

    int            errors = 0;
    int            checks = 0;
    int            xfers  = 0;
    int            mark;
    bit            ovf_m  = 1'b0;
    samp_t         exp_q[$];
    logic [DW-1:0] fr_re [N];
    logic [DW-1:0] fr_im [N];

    fft_output_serializer #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .x_in_flat_real (x_in_flat_real),
        .x_in_flat_imag (x_in_flat_imag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_real       (out_real),
        .out_imag       (out_imag),
        .out_index      (out_index),
        .out_last       (out_last),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    function automatic int brev(input int k);
        int r = 0;
        for (int j = 0; j < 4; j++) begin
            r = r | (((k >> j) & 1) << (3 - j));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: bin i = (i+1, -(i+1)); mode 1: random samples
    task automatic make_frame(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                fr_re[i] = DW'(i + 1);
                fr_im[i] = DW'(-(i + 1));
            end else begin
                fr_re[i] = DW'($urandom);
                fr_im[i] = DW'($urandom);
            end
        end
    endtask

    // One cycle: check outputs against the model, then drive inputs for the next edge.
    task automatic cyc(input bit iv, input bit ordy, input bit r);
        int    frames;
        bit    accept;
        samp_t s;
        frames = (exp_q.size() + N - 1) / N;
        check("in_ready", in_ready, frames < 2);
        check("overflow", overflow, ovf_m);
        check("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("out_real", out_real, exp_q[0].re);
            check("out_imag", out_imag, exp_q[0].im);
            check("out_index", out_index, exp_q[0].idx);
            check("out_last", out_last, exp_q[0].last);
        end else begin
            check("out_last_idle", out_last, 0);
        end

        rst       = r;
        in_valid  = iv;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            x_in_flat_real[DW*(N-i)-1 -: DW] = iv ? fr_re[i] : DW'($urandom);
            x_in_flat_imag[DW*(N-i)-1 -: DW] = iv ? fr_im[i] : DW'($urandom);
        end

        if (r) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end else begin
            accept = iv && (frames < 2);
            if (iv && !accept) ovf_m = 1'b1;
            if (ordy && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    int bin;
                    bin    = BITREV_EN ? brev(k) : k;
                    s.re   = fr_re[bin];
                    s.im   = fr_im[bin];
                    s.idx  = 4'(BITREV_EN ? k : brev(k));
                    s.last = (k == N - 1);
                    exp_q.push_back(s);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        x_in_flat_real = '0;
        x_in_flat_imag = '0;

        // 1: reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);

        // 2: single ramp frame, sink always ready
        make_frame(0);
        mark = xfers;
        cyc(1, 1, 0);
        repeat (20) cyc(0, 1, 0);
        check("single_frame_xfers", xfers - mark, 16);

        // 3: back-to-back frames 16 cycles apart, contiguous output
        mark = xfers;
        for (int f = 0; f < 4; f++) begin
            make_frame(1);
            cyc(1, 1, 0);
            repeat (15) cyc(0, 1, 0);
        end
        repeat (4) cyc(0, 1, 0);
        check("b2b_xfers", xfers - mark, 64);
        check("b2b_no_overflow", overflow, 0);

        // 4: random backpressure and random frame arrival
        for (int c = 0; c < 300; c++) begin
            bit iv;
            iv = ($urandom % 8) == 0;
            if (iv) make_frame(1);
            cyc(iv, 1'($urandom % 2), 0);
        end
        repeat (40) cyc(0, 1, 0);

        // 5: stalled sink, three frames: third is dropped
        cyc(0, 0, 1);
        mark = xfers;
        make_frame(1); cyc(1, 0, 0);
        make_frame(1); cyc(1, 0, 0);
        make_frame(1); cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        check("ovf_set", overflow, 1);
        repeat (40) cyc(0, 1, 0);
        check("ovf_drained", xfers - mark, 32);
        check("ovf_sticky", overflow, 1);

        // 6: reset after 5 transfers, then a fresh frame from slot 0
        make_frame(1);
        cyc(1, 1, 0);
        repeat (5) cyc(0, 1, 0);
        cyc(0, 1, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_overflow", overflow, 0);
        make_frame(0);
        mark = xfers;
        cyc(1, 1, 0);
        repeat (20) cyc(0, 1, 0);
        check("midrst_xfers", xfers - mark, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
